// File: rtl/game_match_ctrl.sv
// game_match_ctrl: scores rising edges of two flag inputs, ends a match at WIN_LIMIT and holds gameover.
// Optional tie reporting on simultaneous finish is enabled by defining GAME_TIE_DETECT_EN.
module game_match_ctrl #(
  parameter int WIN_LIMIT   = 15,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       winner_flag,
  input  logic       loser_flag,
  output logic       gameover,
  output logic       who,
  output logic [3:0] win_count,
  output logic [3:0] lose_count,
  output logic       tie
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_OVER  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT     = 4'(WIN_LIMIT);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_win_prev;
  logic       r_lose_prev;
  logic [3:0] r_win_cnt;
  logic [3:0] r_lose_cnt;
  logic [3:0] w_win_cnt_nxt;
  logic [3:0] w_lose_cnt_nxt;
  logic [3:0] w_win_inc;
  logic [3:0] w_lose_inc;
  logic       r_gameover;
  logic       w_gameover_nxt;
  logic       r_who;
  logic       w_who_nxt;
  logic       r_tie;
  logic       w_tie_nxt;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic       w_win_edge;
  logic       w_lose_edge;
  logic       w_win_hit;
  logic       w_lose_hit;

  assign w_win_edge  = winner_flag & ~r_win_prev;
  assign w_lose_edge = loser_flag & ~r_lose_prev;
  // Post-increment values decide the match end on the very edge that scores.
  assign w_win_inc   = r_win_cnt + {3'b000, w_win_edge};
  assign w_lose_inc  = r_lose_cnt + {3'b000, w_lose_edge};
  assign w_win_hit   = (w_win_inc == LIMIT);
  assign w_lose_hit  = (w_lose_inc == LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_PLAY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_win_cnt_nxt  = r_win_cnt;
    w_lose_cnt_nxt = r_lose_cnt;
    w_gameover_nxt = r_gameover;
    w_who_nxt      = r_who;
    w_tie_nxt      = r_tie;
    w_hold_nxt     = r_hold;
    case (r_state)
      S_PLAY: begin
        w_win_cnt_nxt  = w_win_inc;
        w_lose_cnt_nxt = w_lose_inc;
        if (w_win_hit || w_lose_hit) begin
          w_state_nxt    = S_OVER;
          w_gameover_nxt = 1'b1;
          w_hold_nxt     = 8'd0;
`ifdef GAME_TIE_DETECT_EN
          w_tie_nxt      = w_win_hit & w_lose_hit;
          w_who_nxt      = w_win_hit & ~w_lose_hit;
`else
          w_tie_nxt      = 1'b0;
          w_who_nxt      = w_win_hit;
`endif
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        // gameover drops on leaving OVER so it is high exactly HOLD_CYCLES cycles.
        if (r_hold == HOLD_LAST) begin
          w_state_nxt    = S_CLEAR;
          w_gameover_nxt = 1'b0;
          w_hold_nxt     = 8'd0;
        end else begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      S_CLEAR: begin
        w_state_nxt    = S_PLAY;
        w_win_cnt_nxt  = 4'd0;
        w_lose_cnt_nxt = 4'd0;
        w_gameover_nxt = 1'b0;
        w_who_nxt      = 1'b0;
        w_tie_nxt      = 1'b0;
        w_hold_nxt     = 8'd0;
      end
      default: begin
        w_state_nxt    = S_PLAY;
        w_win_cnt_nxt  = 4'd0;
        w_lose_cnt_nxt = 4'd0;
        w_gameover_nxt = 1'b0;
        w_who_nxt      = 1'b0;
        w_tie_nxt      = 1'b0;
        w_hold_nxt     = 8'd0;
      end
    endcase
  end

  // Flag samples, tallies, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_prev  <= 1'b0;
      r_lose_prev <= 1'b0;
      r_win_cnt   <= 4'd0;
      r_lose_cnt  <= 4'd0;
      r_gameover  <= 1'b0;
      r_who       <= 1'b0;
      r_tie       <= 1'b0;
      r_hold      <= 8'd0;
    end else begin
      r_win_prev  <= winner_flag;
      r_lose_prev <= loser_flag;
      r_win_cnt   <= w_win_cnt_nxt;
      r_lose_cnt  <= w_lose_cnt_nxt;
      r_gameover  <= w_gameover_nxt;
      r_who       <= w_who_nxt;
      r_tie       <= w_tie_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  assign gameover   = r_gameover;
  assign who        = r_who;
  assign win_count  = r_win_cnt;
  assign lose_count = r_lose_cnt;
  assign tie        = r_tie;

endmodule
